// File: rtl/mem_stage_if.sv
// ============================================================================
// Module   : mem_stage_if
// Purpose  : EX->MEM->WB handshake, data-SRAM response and forwarding signals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;
  logic         es_to_ms_valid;
  logic [114:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [110:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic         ms_fwd_valid;
  logic [4:0]   ms_rf_dest;
  logic [31:0]  ms_rf_wdata;
  logic         ms_ex_o;

  // Surrounding pipeline / environment view
  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
    output data_sram_data_ok, data_sram_rdata, flush,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
    input  ms_fwd_valid, ms_rf_dest, ms_rf_wdata, ms_ex_o
  );

  // MEM stage view
  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
    input  data_sram_data_ok, data_sram_rdata, flush,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
    output ms_fwd_valid, ms_rf_dest, ms_rf_wdata, ms_ex_o
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline MEM stage: waits for data-SRAM responses, aligns load
//            data, and discards responses belonging to flushed requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  ms_if
);

  localparam logic [1:0] C_CNT_MAX = 2'd3;

  logic         r_ms_valid;
  logic [114:0] r_bus;
  logic         r_got_data;
  logic [31:0]  r_rdata_buf;
  logic [1:0]   r_cancel_cnt;

  logic [31:0] w_badvaddr;
  logic [4:0]  w_excode;
  logic        w_ex;
  logic        w_mem_req;
  logic [2:0]  w_load_op;
  logic [3:0]  w_gr_strb;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;

  assign {w_badvaddr, w_excode, w_ex, w_mem_req, w_load_op,
          w_gr_strb, w_dest, w_alu_result, w_pc} = r_bus;

  logic        w_waiting;
  logic        w_own_ok;
  logic        w_stale_ok;
  logic        w_cancel_inc;
  logic        w_ready_go;
  logic        w_allowin;
  logic        w_buffer_rdata;
  logic [1:0]  w_off;
  logic [31:0] w_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_final;

  assign w_waiting  = r_ms_valid & w_mem_req & ~w_ex & ~r_got_data;
  // A response belongs to MEM's own request only once all stale ones drained
  assign w_own_ok   = ms_if.data_sram_data_ok & (r_cancel_cnt == 2'd0);
  assign w_stale_ok = ms_if.data_sram_data_ok & (r_cancel_cnt != 2'd0);
  assign w_cancel_inc = ms_if.flush & w_waiting & ~w_own_ok;

  assign w_ready_go = ~w_waiting | w_own_ok;
  assign w_allowin  = ~r_ms_valid | (w_ready_go & ms_if.ws_allowin);
  assign w_buffer_rdata = w_waiting & w_own_ok & ~ms_if.ws_allowin & ~ms_if.flush;

  assign w_off   = w_alu_result[1:0];
  assign w_rdata = r_got_data ? r_rdata_buf : ms_if.data_sram_rdata;
  assign w_byte  = w_rdata[{w_off, 3'b000} +: 8];
  assign w_half  = w_off[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_final = w_alu_result;
    case (w_load_op)
      3'd1:    w_final = w_rdata;
      3'd2:    w_final = {{24{w_byte[7]}}, w_byte};
      3'd3:    w_final = {24'd0, w_byte};
      3'd4:    w_final = {{16{w_half[15]}}, w_half};
      3'd5:    w_final = {16'd0, w_half};
      default: w_final = w_alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ms_valid <= 1'b0;
    end else if (ms_if.flush) begin
      r_ms_valid <= 1'b0;
    end else if (w_allowin) begin
      r_ms_valid <= ms_if.es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus <= '0;
    end else if (ms_if.es_to_ms_valid && w_allowin) begin
      r_bus <= ms_if.es_to_ms_bus;
    end
  end

  // Holds a response that arrived while WB was stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_got_data  <= 1'b0;
      r_rdata_buf <= 32'd0;
    end else if (ms_if.flush) begin
      r_got_data  <= 1'b0;
      r_rdata_buf <= 32'd0;
    end else if (w_buffer_rdata) begin
      r_got_data  <= 1'b1;
      r_rdata_buf <= ms_if.data_sram_rdata;
    end else if (w_allowin) begin
      r_got_data  <= 1'b0;
      r_rdata_buf <= 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cancel_cnt <= 2'd0;
    end else if (w_cancel_inc && !w_stale_ok) begin
      if (r_cancel_cnt != C_CNT_MAX) begin
        r_cancel_cnt <= r_cancel_cnt + 2'd1;
      end
    end else if (!w_cancel_inc && w_stale_ok) begin
      r_cancel_cnt <= r_cancel_cnt - 2'd1;
    end
  end

  assign ms_if.ms_allowin     = w_allowin;
  assign ms_if.ms_to_ws_valid = r_ms_valid & w_ready_go & ~ms_if.flush;
  assign ms_if.ms_to_ws_bus   = {w_badvaddr, w_excode, w_ex, w_gr_strb,
                                 w_dest, w_final, w_pc};
  assign ms_if.ms_fwd_valid   = r_ms_valid & w_ready_go & (w_gr_strb != 4'd0) & ~w_ex;
  assign ms_if.ms_rf_dest     = (r_ms_valid && w_gr_strb != 4'd0) ? w_dest : 5'd0;
  assign ms_if.ms_rf_wdata    = w_final;
  assign ms_if.ms_ex_o        = r_ms_valid & w_ex;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed and randomized checks of mem_stage against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic [4:0]  excode;
    logic        ex;
    logic        mem_req;
    logic [2:0]  load_op;
    logic [3:0]  gr_strb;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
  } instr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if bus_if();
  mem_stage dut (.clk(clk), .reset(reset), .ms_if(bus_if));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Stimulus for the current cycle
  logic        in_ev, in_ws, in_dok, in_flush, in_rst;
  instr_t      in_ins;
  logic [31:0] in_rdata;

  // Reference model: the instruction held in MEM plus abandoned responses
  logic        m_valid;
  instr_t      m_ins;
  logic        m_have;
  logic [31:0] m_buf;
  int          m_stale;

  logic        e_waiting, e_own, e_ready, e_allow, e_out;
  logic [31:0] e_final;

  function automatic logic [31:0] load_result(input instr_t ins, input logic [31:0] data);
    int unsigned off, b, h;
    off = ins.alu % 4;
    b = (data >> (8 * off)) & 32'hFF;
    h = (data >> (16 * (off / 2))) & 32'hFFFF;
    case (ins.load_op)
      3'd1:    return data;
      3'd2:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd3:    return b;
      3'd4:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return ins.alu;
    endcase
  endfunction

  function automatic logic model_waiting();
    return m_valid && m_ins.mem_req && !m_ins.ex && !m_have;
  endfunction

  task automatic idle();
    in_ev = 0; in_ins = '0; in_ws = 1; in_dok = 0;
    in_rdata = 0; in_flush = 0; in_rst = 0;
  endtask

  task automatic compare_model();
    logic        e_fwd;
    logic [4:0]  e_dest;
    logic [110:0] e_bus, got_bus;
    e_waiting = model_waiting();
    e_own     = in_dok && (m_stale == 0);
    e_ready   = !e_waiting || e_own;
    e_allow   = !m_valid || (e_ready && in_ws);
    e_out     = m_valid && e_ready && !in_flush;
    e_fwd     = m_valid && e_ready && (m_ins.gr_strb != 0) && !m_ins.ex;
    e_dest    = (m_valid && m_ins.gr_strb != 0) ? m_ins.dest : 5'd0;
    e_final   = load_result(m_ins, m_have ? m_buf : in_rdata);
    check("allowin", bus_if.ms_allowin, e_allow);
    check("to_ws_valid", bus_if.ms_to_ws_valid, e_out);
    check("fwd_valid", bus_if.ms_fwd_valid, e_fwd);
    check("rf_dest", bus_if.ms_rf_dest, e_dest);
    check("ex_o", bus_if.ms_ex_o, m_valid && m_ins.ex);
    if (e_out) begin
      e_bus = {m_ins.badvaddr, m_ins.excode, m_ins.ex, m_ins.gr_strb,
               m_ins.dest, e_final, m_ins.pc};
      got_bus = bus_if.ms_to_ws_bus;
      // Result of an excepting instruction is don't-care
      if (m_ins.ex) begin
        e_bus[63:32] = 32'd0;
        got_bus[63:32] = 32'd0;
      end
      check("to_ws_bus", got_bus, e_bus);
    end
    if (e_fwd) check("rf_wdata", bus_if.ms_rf_wdata, e_final);
  endtask

  task automatic apply();
    bus_if.es_to_ms_valid    = in_ev;
    bus_if.es_to_ms_bus      = in_ins;
    bus_if.ws_allowin        = in_ws;
    bus_if.data_sram_data_ok = in_dok;
    bus_if.data_sram_rdata   = in_rdata;
    bus_if.flush             = in_flush;
    reset                    = in_rst;
    #1;
    compare_model();
  endtask

  task automatic tick();
    int ns;
    if (in_rst) begin
      m_valid = 0; m_have = 0; m_buf = 0; m_stale = 0; m_ins = '0;
    end else begin
      ns = m_stale - ((in_dok && m_stale > 0) ? 1 : 0)
                   + ((in_flush && e_waiting && !e_own) ? 1 : 0);
      m_stale = (ns > 3) ? 3 : ns;
      if (in_flush) begin
        m_valid = 0; m_have = 0;
      end else if (e_waiting && e_own && !in_ws) begin
        m_have = 1; m_buf = in_rdata;
      end else if (e_allow) begin
        m_have = 0; m_valid = in_ev;
        if (in_ev) m_ins = in_ins;
      end
    end
    @(negedge clk);
  endtask

  function automatic instr_t mk(input logic mem_req, input logic [2:0] lop,
                                input logic [31:0] alu);
    instr_t t;
    t = '0;
    t.mem_req = mem_req; t.load_op = lop; t.alu = alu;
    t.gr_strb = 4'hF; t.dest = 5'd7; t.pc = 32'h1C00_0000 + alu;
    return t;
  endfunction

  task automatic enter(input instr_t ins);
    idle(); in_ev = 1; in_ins = ins; apply(); tick();
  endtask

  initial begin
    m_valid = 0; m_have = 0; m_buf = 0; m_stale = 0; m_ins = '0;
    idle();
    in_rst = 1;
    bus_if.es_to_ms_valid = 0; bus_if.es_to_ms_bus = '0; bus_if.ws_allowin = 1;
    bus_if.data_sram_data_ok = 0; bus_if.data_sram_rdata = 0; bus_if.flush = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    idle(); apply();
    check("rst_to_ws_valid", bus_if.ms_to_ws_valid, 0);
    check("rst_allowin", bus_if.ms_allowin, 1);
    check("rst_fwd_valid", bus_if.ms_fwd_valid, 0);
    check("rst_rf_dest", bus_if.ms_rf_dest, 0);
    check("rst_ex_o", bus_if.ms_ex_o, 0);
    tick();

    // lb with same-cycle response
    enter(mk(1, 3'd2, 32'h1003));
    idle(); in_dok = 1; in_rdata = 32'h80FF_FF12; apply();
    check("lb_valid", bus_if.ms_to_ws_valid, 1);
    check("lb_result", bus_if.ms_to_ws_bus[63:32], 32'hFFFF_FF80);
    tick();

    // lhu buffered across a 3-cycle WB stall
    enter(mk(1, 3'd5, 32'h2002));
    idle(); in_ws = 0; in_dok = 1; in_rdata = 32'hBEEF_0000; apply(); tick();
    idle(); in_ws = 0; apply(); tick();
    idle(); in_ws = 0; apply(); tick();
    idle(); apply();
    check("lhu_result", bus_if.ms_to_ws_bus[63:32], 32'h0000_BEEF);
    check("lhu_allowin", bus_if.ms_allowin, 1);
    tick();

    // Flushed lw leaves a stale response to discard
    enter(mk(1, 3'd1, 32'h3000));
    idle(); in_flush = 1; apply(); tick();
    check("cancel_one", dut.r_cancel_cnt, 2'd1);
    enter(mk(1, 3'd1, 32'h3004));
    idle(); in_dok = 1; in_rdata = 32'h0000_DEAD; apply();
    check("stale_blocked", bus_if.ms_to_ws_valid, 0);
    tick();
    idle(); in_dok = 1; in_rdata = 32'h0000_1234; apply();
    check("after_stale_valid", bus_if.ms_to_ws_valid, 1);
    check("after_stale_result", bus_if.ms_to_ws_bus[63:32], 32'h0000_1234);
    tick();

    // Flush coincident with own response
    enter(mk(1, 3'd1, 32'h3008));
    idle(); in_dok = 1; in_flush = 1; in_rdata = 32'h5555; apply();
    check("flush_ok_valid", bus_if.ms_to_ws_valid, 0);
    tick();
    check("flush_ok_cancel", dut.r_cancel_cnt, 2'd0);

    // Excepting load passes without waiting
    begin
      instr_t t;
      t = mk(1, 3'd1, 32'h1001);
      t.ex = 1; t.excode = 5'd4; t.badvaddr = 32'h1001;
      enter(t);
      idle(); apply();
      check("ex_valid", bus_if.ms_to_ws_valid, 1);
      check("ex_o", bus_if.ms_ex_o, 1);
      check("ex_fwd", bus_if.ms_fwd_valid, 0);
      check("ex_excode", bus_if.ms_to_ws_bus[78:74], 5'd4);
      check("ex_badvaddr", bus_if.ms_to_ws_bus[110:79], 32'h1001);
      tick();
    end

    // Reset during a wait with two stale responses outstanding
    enter(mk(1, 3'd1, 32'h4000));
    idle(); in_flush = 1; apply(); tick();
    enter(mk(1, 3'd1, 32'h4004));
    idle(); in_flush = 1; apply(); tick();
    check("cancel_two", dut.r_cancel_cnt, 2'd2);
    enter(mk(1, 3'd1, 32'h4008));
    idle(); in_rst = 1; apply(); tick();
    enter(mk(0, 3'd0, 32'h4010));
    idle(); apply();
    check("post_rst_alu", bus_if.ms_to_ws_valid, 1);
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int outstanding;
      instr_t t;
      idle();
      outstanding = m_stale + (model_waiting() ? 1 : 0);
      t.badvaddr = $urandom; t.excode = 5'($urandom); t.ex = ($urandom % 10) == 0;
      t.mem_req = 1'($urandom); t.load_op = t.mem_req ? 3'($urandom) : 3'd0;
      t.gr_strb = (($urandom % 4) == 0) ? 4'd0 : 4'($urandom);
      t.dest = 5'($urandom); t.alu = $urandom; t.pc = $urandom;
      in_ins   = t;
      in_ev    = ($urandom % 4) != 0;
      in_ws    = ($urandom % 4) != 0;
      in_flush = ($urandom % 12) == 0;
      in_rst   = ($urandom % 300) == 0;
      in_dok   = (outstanding > 0) && (($urandom % 3) == 0);
      in_rdata = $urandom;
      apply();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
